main_mem_hs: RTL

- Parametrised successor to the CPU's flat byte-lane main memory.
- Same byte-enable word storage, but accessed through a valid/ready request/response handshake with a programmable wait-state latency, so the core can model slow memory and stall correctly.
- Sits between the CPU's memory-stage/fetch arbiter and the storage array.
- One request is outstanding at a time.

---
 rtl/main_mem_pkg.sv | 22 ++
 rtl/main_mem_byte_lane.sv | 24 ++
 rtl/main_mem_hs.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/main_mem_pkg.sv
// Shared types and helpers for the handshaked main memory (main_mem_hs).
package main_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int LAT_W = 4;

   // Ceiling log2, used at elaboration time for lane-offset and index widths.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/main_mem_byte_lane.sv
// One byte lane of main memory: DEPTH x 8 storage with write enable and registered read.
module mem_byte_lane #(
   parameter int DEPTH = 131072,
   parameter int IW    = 17
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [IW-1:0] idx_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[idx_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[idx_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_hs.sv
// Byte-lane main memory behind a valid/ready request/response handshake with LATENCY wait states.
// Optional out-of-range detection on upper address bits is enabled by defining MAIN_MEM_RANGE_CHK_EN.
module main_mem_hs
   import main_mem_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int DEPTH   = 131072,
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW/8-1:0] req_sel,
   input  logic [DW-1:0]   req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_rdata,
   output logic            rsp_err
);

   localparam int NB  = DW / 8;
   localparam int OFF = clog2(NB);
   localparam int IW  = clog2(DEPTH);

   state_e           state_q;
   logic [LAT_W-1:0] cnt_q;
   logic             req_ready_q;
   logic             rsp_valid_q;
   logic             rd_vld_q;

   logic             we_q;
   logic [IW-1:0]    idx_q;
   logic [NB-1:0]    sel_q;
   logic [DW-1:0]    wdata_q;
   logic             oor_d;
   logic             oor_q;

   logic             accept;
   logic             commit;
   logic [NB-1:0]    lane_we;
   logic             lane_re;
   logic [DW-1:0]    lane_rdata;
   logic             addr_unused;

   assign accept = req_valid && req_ready_q;
   // Reset has priority over the commit edge, so a latched write is dropped.
   assign commit = (state_q == WAIT) && (cnt_q == '0) && !rst;

`ifdef MAIN_MEM_RANGE_CHK_EN
   assign oor_d = |req_addr[AW-1:OFF+IW];
`else
   assign oor_d = 1'b0;
`endif

   // Low offset bits (and upper bits without range checking) do not select storage.
   assign addr_unused = ^req_addr;

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         idx_q   <= req_addr[OFF+IW-1:OFF];
         sel_q   <= req_sel;
         wdata_q <= req_wdata;
         oor_q   <= oor_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rd_vld_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  state_q     <= WAIT;
                  cnt_q       <= LAT_W'(LATENCY);
                  req_ready_q <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rd_vld_q    <= !we_q && !oor_q;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               cnt_q       <= '0;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rd_vld_q    <= 1'b0;
            end
         endcase
      end
   end

`ifdef MAIN_MEM_RANGE_CHK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (commit) begin
         err_q <= oor_q;
      end
   end

   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign lane_re = commit && !we_q && !oor_q;

   for (genvar g = 0; g < NB; g++) begin : g_lane
      assign lane_we[g] = commit && we_q && sel_q[g] && !oor_q;

      mem_byte_lane #(
         .DEPTH (DEPTH),
         .IW    (IW)
      ) u_lane (
         .clk     (clk),
         .we_i    (lane_we[g]),
         .re_i    (lane_re),
         .idx_i   (idx_q),
         .wdata_i (wdata_q[8*g +: 8]),
         .rdata_o (lane_rdata[8*g +: 8])
      );
   end

   // The lane read registers only change on a read commit, so the response stays stable in RESP.
   assign rsp_rdata = rd_vld_q ? lane_rdata : '0;
   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;

endmodule
